// File: rtl/memwb_elastic_pipe_pkg.sv
// memwb_pkg: shared FSM state, width defaults and payload field offsets for the MEM/WB pipe
package memwb_pkg;
  localparam int PAYLOAD_W_DEF = 163;
  localparam int CNT_W_DEF = 16;
  localparam int OFF_PRE_ADDR = 0;
  localparam int OFF_INSTR = 32;
  localparam int OFF_WRAP_LOAD = 64;
  localparam int OFF_NEXT_SEL = 96;
  localparam int OFF_ALU_RES = 128;
  localparam int OFF_MEM_REG = 160;
  localparam int OFF_REG_WRITE = 162;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
endpackage

// File: rtl/memwb_elastic_pipe_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-low reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (!rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/memwb_elastic_pipe.sv
// memwb_elastic_pipe: two-entry skid buffer between MEM and WB with flush and stall counter
module memwb_elastic_pipe
  import memwb_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt
);
  state_t state, state_nx;
  logic [PAYLOAD_W-1:0] main_q, skid_q, main_nx, skid_nx;
  logic in_fire, out_fire;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data = main_q;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    main_nx = main_q;
    skid_nx = skid_q;
    case (state)
      EMPTY: if (in_fire) begin
        main_nx = in_data;
        state_nx = BUSY;
      end
      BUSY: begin
        main_nx = in_fire && out_fire ? in_data : main_q;
        skid_nx = in_fire && !out_fire ? in_data : skid_q;
        state_nx = in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : BUSY;
      end
      FULL: if (out_fire) begin
        main_nx = skid_q;
        state_nx = BUSY;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      main_nx = '0;
      skid_nx = '0;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk),
    .rst(rst),
    .inc(out_valid & ~out_ready),
    .count(stall_cnt)
  );
endmodule

// File: tb/tb_memwb_elastic_pipe.sv
// tb_memwb_elastic_pipe: randomized and directed scoreboard bench for the MEM/WB elastic pipe
module tb_memwb_elastic_pipe;
  localparam int PW = 163;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0, out_ready = 0, flush = 0;
  logic [PW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [PW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  int checks = 0, failures = 0;
  logic [PW-1:0] exp_q[$];
  bit pushed = 0;
  logic [PW-1:0] last = '0;
  int scnt = 0;
  logic [PW-1:0] seen_c = 'hC;
  memwb_elastic_pipe #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // Inputs change at negedge; the expected payload is queued the moment a transfer is issued.
  task automatic drive(input logic r, input logic iv, input logic [PW-1:0] d, input logic fl, input logic ordy);
    @(negedge clk);
    rst = r;
    in_valid = iv;
    in_data = d;
    flush = fl;
    out_ready = ordy;
    pushed = r && iv && in_ready && !fl;
    if (pushed) exp_q.push_back(d);
  endtask
  function automatic logic [PW-1:0] rnd_data();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction
  // Reference model: an ideal 2-deep FIFO whose occupancy defines ready/valid.
  initial forever begin
    int n;
    logic [PW-1:0] head;
    @(negedge clk);
    #2;
    n = exp_q.size() - int'(pushed);
    head = n > 0 ? exp_q[0] : last;
    chk("in_ready", {162'b0, in_ready}, {162'b0, n < 2});
    chk("out_valid", {162'b0, out_valid}, {162'b0, n > 0});
    chk("out_data", out_data, head);
    chk("stall_cnt", {159'b0, stall_cnt}, PW'(scnt));
    if (out_valid && out_data === seen_c && seen_c != 0) chk("flushed_c_seen", out_data, '0);
    if (n > 0 && out_ready) begin
      last = exp_q.pop_front();
    end
    if (n > 0 && !out_ready && scnt < SMAX) scnt++;
    if (!rst) scnt = 0;
    if (!rst || flush) begin
      exp_q.delete();
      last = '0;
    end
  end
  initial begin
    drive(0, 1, 'h55, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_in_ready", {162'b0, in_ready}, 1);
    chk("rst_out_valid", {162'b0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", {159'b0, stall_cnt}, 0);
    for (int i = 1; i <= 4; i++) drive(1, 1, PW'(i), 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 'hA, 0, 0);
    drive(1, 1, 'hB, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("bp_in_ready", {162'b0, in_ready}, 0);
    chk("bp_out_data", out_data, 'hA);
    chk("bp_stall", {159'b0, stall_cnt}, 3);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 1, 'hA, 0, 0);
    drive(1, 1, 'hB, 0, 0);
    drive(1, 1, 'hC, 1, 0);
    @(posedge clk);
    #1;
    chk("fl_out_valid", {162'b0, out_valid}, 0);
    chk("fl_in_ready", {162'b0, in_ready}, 1);
    chk("fl_out_data", out_data, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1);
    seen_c = '0;
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 'h77, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("sat_stall", {159'b0, stall_cnt}, 15);
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(499) != 0, $urandom_range(9) < 7, rnd_data(),
            $urandom_range(19) == 0, $urandom_range(9) < 6);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
